stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//   Control sequencer for the BCD stopwatch. Conditions the raw push buttons (sync, debounce,
//   edge detect) and runs the run/pause/idle state machine. Owns the speed-selected prescaler
//   and emits a 1-cycle tick enable plus a 1-cycle clear pulse to the counter datapath.
//   Sits between the board buttons and the BCD counter, and replaces ad-hoc slow-clock generation.
// PARAMETERS
//   DEBOUNCE_CYCLES  1_000_000  consecutive stable cycles needed to accept a button level (>=2)
//   TICK_DIV0        1_000_000  clk cycles per tick at speed 0 (100 Hz at 100 MHz = 0.01 s)
//   TICK_DIV1        100_000    clk cycles per tick at speed 1 (x10)
//   TICK_DIV2        10_000     clk cycles per tick at speed 2 (x100); all TICK_DIVn >= 2
// PORTS
//   clk        in   1  system clock, 100 MHz, all logic on rising edge
//   reset_n    in   1  asynchronous active-low reset
//   btnU       in   1  raw button, speed select (async, bouncy)
//   btnC       in   1  raw button, start/pause (async, bouncy)
//   btnD       in   1  raw button, stop and clear (async, bouncy)
//   tick       out  1  1-cycle count enable to the counter datapath
//   clear      out  1  1-cycle synchronous clear to the counter datapath
//   running    out  1  high while state == RUN
//   speed_sel  out  2  current speed, 0..2
//   state      out  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE (3 unused)
// BEHAVIOUR
//   Reset (reset_n=0, async): state=IDLE; tick=clear=running=0; speed_sel=0; prescaler=0.
//     Sync flops, stable levels and debounce counters are also 0. All outputs are registered.
//   Conditioning (one identical channel per button):
//     - 2-flop synchroniser; debounce counter runs while sync2 != stable, zeroed on any match.
//     - stable <= sync2 when the counter reaches DEBOUNCE_CYCLES-1; counter then returns to 0.
//     - press = registered rising edge of stable, exactly 1 cycle; releases generate no event.
//     - Fixed latency: raw level held from edge k gives state/speed update at edge k+DEBOUNCE_CYCLES+3.
//   FSM, evaluated on press events:
//     IDLE --C--> RUN;  RUN --C--> PAUSE;  PAUSE --C--> RUN.
//     Any state --D--> IDLE, with clear=1 for exactly the cycle state becomes IDLE.
//     D in IDLE still pulses clear. Same-cycle C and D: D wins, C is discarded.
//   Speed: U press sets speed_sel to 0->1->2->0 (wraps) in any state. U is independent of C/D
//     in the same cycle. speed_sel is retained across D (only reset_n returns it to 0).
//   Prescaler: width clog2(max TICK_DIVn); counts only in RUN.
//     - In RUN, tick=1 on the cycle count==DIV(speed_sel)-1; count then wraps to 0.
//     - PAUSE holds the count, so the partial period resumes on return to RUN.
//     - IDLE forces count=0. Any speed change forces count=0 and suppresses a tick that cycle.
//     - First tick after entering RUN from IDLE, or after a speed change, comes DIV cycles later.
//   tick is never high outside RUN and never high in the same cycle as clear.
//   reset_n asserted mid-period or mid-debounce aborts everything; no partial tick or clear is emitted.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, TICK_DIV0=10, TICK_DIV1=5, TICK_DIV2=2)
//   1 Reset: pulse reset_n low off-edge while RUN, tick period active -> outputs 0 with no clk edge;
//     state=0, speed_sel=0.
//   2 Bounce: btnC toggles every 2 cycles for 20 cycles, then held high -> exactly one IDLE->RUN;
//     running rises 7 edges after the final rise; no PAUSE entry.
//   3 Ticking: speed 0 in RUN -> tick every 10 cycles, first tick 10 cycles after running rises;
//     count 5 ticks exactly.
//   4 Pause/resume: pause 3 cycles into a period, wait 50, resume -> no tick while paused;
//     first tick 7 cycles after running reasserts.
//   5 Speed: btnU press in RUN -> speed_sel=1, tick period 5 starting from count 0;
//     two more presses -> 2 then 0 (period 2, then 10).
//   6 Collision: btnC and btnD pressed same cycle in RUN -> state=IDLE, one clear pulse,
//     running=0, no tick afterward; btnD in IDLE -> one clear, state unchanged.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and counter-datapath controls of the stopwatch sequencer.
// master = board/bench side driving the buttons, slave = the sequencer.
interface stopwatch_ctrl_if;
  logic       btnU;
  logic       btnC;
  logic       btnD;
  logic       tick;
  logic       clear;
  logic       running;
  logic [1:0] speed_sel;
  logic [1:0] state;

  modport master (
    output btnU, btnC, btnD,
    input  tick, clear, running, speed_sel, state
  );

  modport slave (
    input  btnU, btnC, btnD,
    output tick, clear, running, speed_sel, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button conditioning (sync, debounce, press
// edge), run/pause/idle FSM, speed select and tick prescaler.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | stopped, prescaler held at 0; entering it pulses clear
//   RUN   | prescaler counts, tick emitted once per period
//   PAUSE | prescaler frozen so the partial period resumes later
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_DIV0       = 1_000_000,
  parameter int TICK_DIV1       = 100_000,
  parameter int TICK_DIV2       = 10_000
) (
  input logic             clk,
  input logic             reset_n,
  stopwatch_ctrl_if.slave sw
);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int MAX_A   = (TICK_DIV0 > TICK_DIV1) ? TICK_DIV0 : TICK_DIV1;
  localparam int MAX_DIV = (MAX_A > TICK_DIV2) ? MAX_A : TICK_DIV2;
  localparam int PS_W    = $clog2(MAX_DIV);
  localparam int B_D     = 0;
  localparam int B_C     = 1;
  localparam int B_U     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  logic [2:0]      rawBtn;
  logic [2:0]      sync1;
  logic [2:0]      sync2;
  logic [2:0]      stable;
  logic [2:0]      stableQ;
  logic [2:0]      press;
  logic [DB_W-1:0] dbCnt [3];

  state_t          stateQ;
  logic            tickQ;
  logic            clearQ;
  logic            runQ;
  logic [1:0]      speedQ;
  logic [PS_W-1:0] psCnt;
  logic [PS_W-1:0] divLast;
  logic            stayRun;
  logic            speedChg;

  assign rawBtn = {sw.btnU, sw.btnC, sw.btnD};

  // Per-button synchroniser, debounce counter and registered press edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= '0;
      sync2   <= '0;
      stable  <= '0;
      stableQ <= '0;
      press   <= '0;
      for (int i = 0; i < 3; i++) dbCnt[i] <= '0;
    end else begin
      sync1   <= rawBtn;
      sync2   <= sync1;
      stableQ <= stable;
      press   <= stable & ~stableQ;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          dbCnt[i] <= '0;
        end else if (dbCnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= sync2[i];
          dbCnt[i]  <= '0;
        end else begin
          dbCnt[i] <= dbCnt[i] + 1'b1;
        end
      end
    end
  end

  // Terminal count of the prescaler for the currently selected speed.
  always_comb begin
    case (speedQ)
      2'd0:    divLast = PS_W'(TICK_DIV0 - 1);
      2'd1:    divLast = PS_W'(TICK_DIV1 - 1);
      default: divLast = PS_W'(TICK_DIV2 - 1);
    endcase
  end

  // Counting only happens on cycles that start and stay in RUN, so a tick
  // can never coincide with a transition out of RUN or with clear.
  assign stayRun  = (stateQ == RUN) && !press[B_D] && !press[B_C];
  assign speedChg = press[B_U];

  // Run/pause/idle FSM with speed select and prescaler; all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateQ <= IDLE;
      tickQ  <= 1'b0;
      clearQ <= 1'b0;
      runQ   <= 1'b0;
      speedQ <= 2'd0;
      psCnt  <= '0;
    end else begin
      tickQ  <= 1'b0;
      clearQ <= 1'b0;

      if (press[B_D]) begin
        stateQ <= IDLE;
        clearQ <= 1'b1;
        runQ   <= 1'b0;
      end else if (press[B_C]) begin
        case (stateQ)
          RUN: begin
            stateQ <= PAUSE;
            runQ   <= 1'b0;
          end
          default: begin
            stateQ <= RUN;
            runQ   <= 1'b1;
          end
        endcase
      end

      if (speedChg) begin
        speedQ <= (speedQ == 2'd2) ? 2'd0 : speedQ + 2'd1;
      end

      if (speedChg) begin
        psCnt <= '0;
      end else if (stayRun) begin
        if (psCnt == divLast) begin
          psCnt <= '0;
          tickQ <= 1'b1;
        end else begin
          psCnt <= psCnt + 1'b1;
        end
      end else if (stateQ == IDLE || press[B_D]) begin
        psCnt <= '0;
      end
    end
  end

  assign sw.tick      = tickQ;
  assign sw.clear     = clearQ;
  assign sw.running   = runQ;
  assign sw.speed_sel = speedQ;
  assign sw.state     = stateQ;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a scoreboard of expected
// state/speed/clear/tick events keyed by clock-edge number.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;
  localparam int EV_STATE = 0;
  localparam int EV_SPEED = 1;
  localparam int EV_CLEAR = 2;
  localparam int EV_TICK  = 3;
  localparam logic [2:0] M_D = 3'b001;
  localparam logic [2:0] M_C = 3'b010;
  localparam logic [2:0] M_U = 3'b100;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   nChecks = 0;
  int   nFail = 0;
  int   rBase;
  int   bBase;
  logic [1:0] prevState = 2'd0;
  logic [1:0] prevSpeed = 2'd0;
  ev_t  evQ[$];

  always #5 clk = ~clk;

  stopwatch_ctrl_if swIf ();

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV0(10),
    .TICK_DIV1(5),
    .TICK_DIV2(2)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .sw     (swIf)
  );

  // edge counter: an event "at cycle n" is visible at the negedge after posedge n
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kindName(input int k);
    case (k)
      EV_STATE: return "state";
      EV_SPEED: return "speed";
      EV_CLEAR: return "clear";
      default:  return "tick";
    endcase
  endfunction

  task automatic pushEv(input int kind, input int val, input int c);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    evQ.push_back(e);
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic matchEv(input int kind, input int val);
    ev_t e;
    nChecks++;
    if (evQ.size() == 0) begin
      nFail++;
      $display("FAIL unexpected_%s: got val=%0d at cycle %0d, required no event",
               kindName(kind), val, cyc);
    end else begin
      e = evQ.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        nFail++;
        $display("FAIL event_%s: got %s=%0d at cycle %0d, required %s=%0d at cycle %0d",
                 kindName(e.kind), kindName(kind), val, cyc, kindName(e.kind), e.val, e.cyc);
      end
    end
  endtask

  // monitor: pop and compare whenever the DUT presents an event
  always @(negedge clk) begin
    if (!reset_n) begin
      prevState = swIf.state;
      prevSpeed = swIf.speed_sel;
    end else begin
      while (evQ.size() > 0 && evQ[0].cyc < cyc) begin
        nChecks++;
        nFail++;
        $display("FAIL missing_%s: got nothing by cycle %0d, required %s=%0d at cycle %0d",
                 kindName(evQ[0].kind), cyc, kindName(evQ[0].kind), evQ[0].val, evQ[0].cyc);
        void'(evQ.pop_front());
      end
      if (swIf.state != prevState) begin
        matchEv(EV_STATE, int'(swIf.state));
        prevState = swIf.state;
      end
      if (swIf.speed_sel != prevSpeed) begin
        matchEv(EV_SPEED, int'(swIf.speed_sel));
        prevSpeed = swIf.speed_sel;
      end
      if (swIf.clear) matchEv(EV_CLEAR, 0);
      if (swIf.tick)  matchEv(EV_TICK, 0);
      checkVal("running_vs_state", int'(swIf.running), int'(swIf.state == 2'd1));
      checkVal("tick_outside_run_or_with_clear",
               int'(swIf.tick && (swIf.clear || swIf.state != 2'd1)), 0);
    end
  end

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pressBtns(input logic [2:0] m);
    swIf.btnU = m[2];
    swIf.btnC = m[1];
    swIf.btnD = m[0];
    repeat (8) @(negedge clk);
    swIf.btnU = 1'b0;
    swIf.btnC = 1'b0;
    swIf.btnD = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no end of stimulus by %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    swIf.btnU = 1'b0;
    swIf.btnC = 1'b0;
    swIf.btnD = 1'b0;
    reset_n   = 1'b0;
    repeat (3) @(negedge clk);
    checkVal("reset_state", int'(swIf.state), 0);
    checkVal("reset_speed", int'(swIf.speed_sel), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    bBase = cyc;
    rBase = bBase + 28;

    // expected event stream, chronological
    pushEv(EV_STATE, 1, rBase);
    for (int k = 1; k <= 5; k++) pushEv(EV_TICK, 0, rBase + 10 * k);
    pushEv(EV_STATE, 2, rBase + 54);
    pushEv(EV_STATE, 1, rBase + 104);
    pushEv(EV_TICK, 0, rBase + 111);
    pushEv(EV_SPEED, 1, rBase + 115);
    pushEv(EV_TICK, 0, rBase + 120);
    pushEv(EV_TICK, 0, rBase + 125);
    pushEv(EV_TICK, 0, rBase + 130);
    pushEv(EV_SPEED, 2, rBase + 133);
    for (int c = 135; c <= 149; c += 2) pushEv(EV_TICK, 0, rBase + c);
    pushEv(EV_SPEED, 0, rBase + 151);
    pushEv(EV_TICK, 0, rBase + 161);
    pushEv(EV_TICK, 0, rBase + 171);
    pushEv(EV_STATE, 0, rBase + 175);
    pushEv(EV_CLEAR, 0, rBase + 175);
    pushEv(EV_CLEAR, 0, rBase + 193);
    pushEv(EV_SPEED, 1, rBase + 208);
    pushEv(EV_CLEAR, 0, rBase + 224);
    pushEv(EV_STATE, 1, rBase + 240);

    // bouncy start: 2-cycle toggles for 20 cycles, then held high
    for (int i = 0; i < 10; i++) begin
      swIf.btnC = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    swIf.btnC = 1'b1;
    waitUntil(bBase + 30);
    swIf.btnC = 1'b0;

    // pause with 3 counts into the period, resume 50 cycles later
    waitUntil(rBase + 46);
    pressBtns(M_C);
    waitUntil(rBase + 96);
    pressBtns(M_C);

    // speed 0 -> 1 -> 2 -> 0; last change lands on a would-be tick
    waitUntil(rBase + 107);
    pressBtns(M_U);
    waitUntil(rBase + 125);
    pressBtns(M_U);
    waitUntil(rBase + 143);
    pressBtns(M_U);

    // same-cycle start and stop in RUN, then stop while IDLE
    waitUntil(rBase + 167);
    pressBtns(M_C | M_D);
    waitUntil(rBase + 185);
    pressBtns(M_D);

    // speed changes in IDLE and survives a stop
    waitUntil(rBase + 200);
    pressBtns(M_U);
    waitUntil(rBase + 216);
    pressBtns(M_D);

    // async reset mid-period while running at speed 1
    waitUntil(rBase + 232);
    pressBtns(M_C);
    waitUntil(rBase + 243);
    checkVal("pre_reset_running", int'(swIf.running), 1);
    #2 reset_n = 1'b0;
    #1;
    checkVal("async_reset_tick", int'(swIf.tick), 0);
    checkVal("async_reset_clear", int'(swIf.clear), 0);
    checkVal("async_reset_running", int'(swIf.running), 0);
    checkVal("async_reset_state", int'(swIf.state), 0);
    checkVal("async_reset_speed", int'(swIf.speed_sel), 0);
    @(negedge clk);
    #2 reset_n = 1'b1;

    repeat (30) @(negedge clk);
    checkVal("events_left_in_queue", evQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
